// File: rtl/aes_pkcs7_block_packer.sv
// aes_pkcs7_block_packer: packs a byte stream into 128-bit AES plaintext blocks with PKCS#7 padding
// First byte lands in [127:120]; one block buffer, so input stalls while a block is on offer.
module aes_pkcs7_block_packer #(
    parameter bit PAD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [127:0]     blk_data,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             blk_last,
    output logic [CNT_W-1:0] blk_index
);
    typedef enum logic {FILL, EMIT} state_t;
    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d, n;
    logic [127:0]       data_q, data_d;
    logic               last_q, last_d, pad_q, pad_d, rdy_q, acc, full;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [7:0]         fill_byte;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        last_d    = last_q;
        pad_d     = pad_q;
        idx_d     = idx_q;
        n         = cnt_q + 5'd1;
        full      = n == 5'd16;
        fill_byte = PAD_EN ? {3'b000, 5'd16 - n} : 8'h00;
        acc       = rdy_q && in_valid;
        if (acc) begin
            cnt_d = n;
            for (int i = 0; i < 16; i++)
                if (5'(i) == cnt_q)
                    data_d[8*(15-i) +: 8] = in_data;
                else if (in_last && 5'(i) > cnt_q)
                    data_d[8*(15-i) +: 8] = fill_byte;
            if (full || in_last) begin
                state_d = EMIT;
                // a full final block under PKCS#7 still owes a whole pad block
                last_d  = in_last && !(full && PAD_EN);
                pad_d   = in_last && full && PAD_EN;
            end
        end else if (state_q == EMIT && blk_ready) begin
            if (pad_q) begin
                data_d = {16{8'h10}};
                last_d = 1'b1;
                pad_d  = 1'b0;
                idx_d  = idx_q + CNT_W'(1);
            end else begin
                state_d = FILL;
                cnt_d   = 5'd0;
                last_d  = 1'b0;
                idx_d   = last_q ? '0 : idx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= 5'd0;
            data_q  <= '0;
            last_q  <= 1'b0;
            pad_q   <= 1'b0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            last_q  <= last_d;
            pad_q   <= pad_d;
            idx_q   <= idx_d;
            rdy_q   <= state_d == FILL;
        end
    end

    assign in_ready  = rdy_q;
    assign blk_valid = state_q == EMIT;
    assign blk_data  = data_q;
    assign blk_last  = last_q;
    assign blk_index = idx_q;
endmodule

// File: tb/tb_aes_pkcs7_block_packer.sv
// tb_aes_pkcs7_block_packer: scoreboard bench for the packer, padded and zero-fill variants
module tb_aes_pkcs7_block_packer;
    typedef struct {logic [127:0] d; logic l; logic [15:0] i;} exp_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic [7:0]   in_data = '0, d0 = '0;
    logic         in_valid = 1'b0, in_last = 1'b0, v0 = 1'b0, l0 = 1'b0;
    logic         in_ready, r0;
    logic [127:0] blk_data, bd0;
    logic         blk_valid, bv0, blk_last, bl0;
    logic         blk_ready = 1'b1, br0 = 1'b1;
    logic [15:0]  blk_index, bi0;

    exp_t q1[$], q0[$];
    int vectors = 0, errs = 0;

    localparam logic [127:0] T1   = 128'h0011220d0d0d0d0d0d0d0d0d0d0d0d0d;
    localparam logic [127:0] SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PADB = 128'h10101010101010101010101010101010;
    localparam logic [127:0] T3B  = 128'h101112130c0c0c0c0c0c0c0c0c0c0c0c;
    localparam logic [127:0] T6A  = 128'h00112200000000000000000000000000;

    aes_pkcs7_block_packer #(.PAD_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_last(blk_last), .blk_index(blk_index));

    aes_pkcs7_block_packer #(.PAD_EN(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_last(l0),
        .in_ready(r0), .blk_data(bd0), .blk_valid(bv0), .blk_ready(br0),
        .blk_last(bl0), .blk_index(bi0));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input bit s, input logic [7:0] d, input bit l);
        int t = 0;
        if (s) begin d0 = d; l0 = l; v0 = 1'b1; end
        else begin in_data = d; in_last = l; in_valid = 1'b1; end
        while (!(s ? r0 : in_ready) && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) chk("send timeout", 128'(t), 128'd0);
        @(posedge clk); #1;
        if (s) begin v0 = 1'b0; l0 = 1'b0; end
        else begin in_valid = 1'b0; in_last = 1'b0; end
    endtask

    task automatic push(input bit s, input logic [127:0] d, input bit l, input logic [15:0] i);
        exp_t e;
        e.d = d; e.l = l; e.i = i;
        if (s) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((q1.size() != 0 || q0.size() != 0) && t < 200) begin @(negedge clk); t++; end
        chk("drain", 128'(q1.size() + q0.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && blk_valid && blk_ready) begin
            if (q1.size() == 0) chk("unexpected block", blk_data, 128'd0);
            else begin
                e = q1.pop_front();
                chk("blk_data", blk_data, e.d);
                chk("blk_last", 128'(blk_last), 128'(e.l));
                chk("blk_index", 128'(blk_index), 128'(e.i));
            end
        end
        if (!rst && bv0 && br0) begin
            if (q0.size() == 0) chk("unexpected block0", bd0, 128'd0);
            else begin
                e = q0.pop_front();
                chk("blk_data0", bd0, e.d);
                chk("blk_last0", 128'(bl0), 128'(e.l));
                chk("blk_index0", 128'(bi0), 128'(e.i));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 128'(in_ready), 128'd0);
        chk("reset blk_valid", 128'(blk_valid), 128'd0);
        chk("reset blk_data", blk_data, 128'd0);
        chk("reset blk_last/index", {111'd0, blk_last, blk_index}, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready held after reset", 128'(in_ready), 128'd0);
        // T1
        push(0, T1, 1'b1, 16'd0);
        send(0, 8'h00, 0); send(0, 8'h11, 0); send(0, 8'h22, 1);
        drain();
        // T2
        push(0, SEQ, 1'b0, 16'd0);
        push(0, PADB, 1'b1, 16'd1);
        for (int k = 0; k < 16; k++) send(0, 8'(k), k == 15);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("T2 in_ready between blocks", 128'(in_ready), 128'd0);
            chk("T2 blk_valid between blocks", 128'(blk_valid), 128'd1);
        end
        drain();
        // T3
        push(0, SEQ, 1'b0, 16'd0);
        push(0, T3B, 1'b1, 16'd1);
        for (int k = 0; k < 20; k++) send(0, 8'(k), k == 19);
        drain();
        // T4
        blk_ready = 1'b0;
        push(0, T1, 1'b1, 16'd0);
        send(0, 8'h00, 0); send(0, 8'h11, 0); send(0, 8'h22, 1);
        in_data = 8'h55; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_last = k[0];
            chk("T4 stall valid", 128'(blk_valid), 128'd1);
            chk("T4 stall data", blk_data, T1);
            chk("T4 stall last", 128'(blk_last), 128'd1);
            chk("T4 stall in_ready", 128'(in_ready), 128'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; blk_ready = 1'b1;
        drain();
        // T5
        for (int k = 0; k < 7; k++) send(0, 8'(8'hA0 + k), 0);
        rst = 1'b1;
        #1;
        chk("T5 reset data", blk_data, 128'd0);
        chk("T5 reset flags", {112'd0, in_ready, blk_valid, blk_last, 13'd0}, 128'd0);
        chk("T5 reset index", 128'(blk_index), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(0, T1, 1'b1, 16'd0);
        send(0, 8'h00, 0); send(0, 8'h11, 0); send(0, 8'h22, 1);
        drain();
        // T6: zero-fill variant
        push(1, T6A, 1'b1, 16'd0);
        send(1, 8'h00, 0); send(1, 8'h11, 0); send(1, 8'h22, 1);
        drain();
        push(1, SEQ, 1'b1, 16'd0);
        for (int k = 0; k < 16; k++) send(1, 8'(k), k == 15);
        drain();
        repeat (5) @(negedge clk);
        chk("T6 no extra block", 128'(bv0), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
